// File: rtl/fetch_resp_ctrl_pkg.sv
// Shared frontend fetch package: responder FSM states, fetch index geometry and
// DDR data width, imported by the fetch responder, its interface and its counter.
package fetch_resp_ctrl_pkg;

  localparam int unsigned FETCH_ADDR_W  = 64;
  localparam int unsigned FETCH_DATA_W  = 64;
  localparam int unsigned FETCH_IDX_LSB = 3;
  localparam int unsigned FETCH_IDX_W   = 19;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/fetch_resp_ctrl_if.sv
// Fetch request/response channel between the frontend PC controller (master)
// and the fetch responder (slave).
//   redirect_valid    : frontend flush, kills the in-flight fetch
//   pc_index_valid    : request valid, pc_index the fetch address
//   pc_index_ready    : request accepted this cycle when valid
//   pc_operation_done : one-cycle pulse, pc_read_inst carries the doubleword
interface fetch_resp_ctrl_if
  import fetch_resp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
);
  logic              redirect_valid;
  logic              pc_index_valid;
  logic [ADDR_W-1:0] pc_index;
  logic              pc_index_ready;
  logic              pc_operation_done;
  logic [DATA_W-1:0] pc_read_inst;

  modport master (
    output redirect_valid,
    output pc_index_valid,
    output pc_index,
    input  pc_index_ready,
    input  pc_operation_done,
    input  pc_read_inst
  );

  modport slave (
    input  redirect_valid,
    input  pc_index_valid,
    input  pc_index,
    output pc_index_ready,
    output pc_operation_done,
    output pc_read_inst
  );
endinterface

// File: rtl/fetch_resp_ctrl_perf_cnt.sv
// Wrapping performance counter with increment enable and synchronous reset.
//   clk_i : clock            rst_i : synchronous active-high reset
//   inc_i : add one this cycle cnt_o : current count (wraps modulo 2^CNT_W)
module fetch_resp_ctrl_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_resp_ctrl.sv
// Instruction-fetch responder: accepts one fetch request, issues a single DDR
// doubleword read, and returns the data with a one-cycle done pulse. Fetches
// overtaken by a redirect are dropped so the PC controller never sees stale data.
//   clock, reset        : sole clock, synchronous active-high reset
//   fetch               : fetch channel (slave side)
//   ddr_*               : DDR read port, one read outstanding at most
//   perf_fetch_cnt      : delivered fetches
//   perf_flush_cnt      : fetches discarded by a redirect
module fetch_resp_ctrl
  import fetch_resp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned DATA_W  = FETCH_DATA_W,
  parameter int unsigned IDX_LSB = FETCH_IDX_LSB,
  parameter int unsigned IDX_W   = FETCH_IDX_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  fetch_resp_ctrl_if.slave   fetch,
  output logic               ddr_chip_enable,
  output logic               ddr_write_enable,
  output logic [IDX_W-1:0]   ddr_index,
  input  logic               ddr_ready,
  input  logic               ddr_operation_done,
  input  logic [DATA_W-1:0]  ddr_opload_rdata,
  output logic [CNT_W-1:0]   perf_fetch_cnt,
  output logic [CNT_W-1:0]   perf_flush_cnt
);
  fetch_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              done_q, done_d;
  logic              pc_ready;
  logic              fetch_inc, flush_inc;

  // Address bits outside the doubleword index play no part in the fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch.pc_index[ADDR_W-1:IDX_LSB+IDX_W],
                              fetch.pc_index[IDX_LSB-1:0]};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    inst_d    = inst_q;
    done_d    = 1'b0;
    pc_ready  = 1'b0;
    fetch_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        pc_ready = ~fetch.redirect_valid;
        if (fetch.pc_index_valid && pc_ready) begin
          idx_d   = fetch.pc_index[IDX_LSB +: IDX_W];
          state_d = StReq;
        end
      end
      StReq: begin
        if (ddr_ready) begin
          // Read already launched: a redirect here must still absorb its completion.
          state_d   = fetch.redirect_valid ? StDrain : StWait;
          flush_inc = fetch.redirect_valid;
        end else if (fetch.redirect_valid) begin
          state_d   = StIdle;
          flush_inc = 1'b1;
        end
      end
      StWait: begin
        if (fetch.redirect_valid) begin
          state_d   = ddr_operation_done ? StIdle : StDrain;
          flush_inc = 1'b1;
        end else if (ddr_operation_done) begin
          inst_d    = ddr_opload_rdata;
          done_d    = 1'b1;
          fetch_inc = 1'b1;
          state_d   = StIdle;
        end
      end
      StDrain: begin
        if (ddr_operation_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      inst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      inst_q  <= inst_d;
      done_q  <= done_d;
    end
  end

  assign fetch.pc_index_ready    = pc_ready;
  // A redirect in the pulse cycle makes the delivered fetch stale; hide the pulse.
  assign fetch.pc_operation_done = done_q & ~fetch.redirect_valid;
  assign fetch.pc_read_inst      = inst_q;
  assign ddr_chip_enable         = (state_q == StReq);
  assign ddr_write_enable        = 1'b0;
  assign ddr_index               = idx_q;

  fetch_resp_ctrl_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_fetch_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .inc_i (fetch_inc),
    .cnt_o (perf_fetch_cnt)
  );

  fetch_resp_ctrl_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .inc_i (flush_inc),
    .cnt_o (perf_flush_cnt)
  );
endmodule

// File: tb/tb_fetch_resp_ctrl.sv
// Self-checking bench for fetch_resp_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_fetch_resp_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        ddr_chip_enable, ddr_write_enable;
  logic [18:0] ddr_index;
  logic        ddr_ready, ddr_operation_done;
  logic [63:0] ddr_opload_rdata;
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one request either waiting to launch, or one read in flight.
  logic        m_req, m_fly, m_killed, m_pulse;
  logic [18:0] m_idx;
  logic [63:0] m_inst;
  logic [31:0] m_fetch, m_flush;

  always #5 clock = ~clock;

  fetch_resp_ctrl_if #(.ADDR_W(64), .DATA_W(64)) fif ();

  fetch_resp_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .fetch              (fif.slave),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_index          (ddr_index),
    .ddr_ready          (ddr_ready),
    .ddr_operation_done (ddr_operation_done),
    .ddr_opload_rdata   (ddr_opload_rdata),
    .perf_fetch_cnt     (perf_fetch_cnt),
    .perf_flush_cnt     (perf_flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_req = 0; m_fly = 0; m_killed = 0; m_pulse = 0;
    m_idx = '0; m_inst = '0; m_fetch = '0; m_flush = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fif.redirect_valid = 0; fif.pc_index_valid = 0; fif.pc_index = '0;
    ddr_ready = 0; ddr_operation_done = 0; ddr_opload_rdata = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic rv, input logic piv, input logic [63:0] pc,
                      input logic rdy, input logic dn, input logic [63:0] rd);
    @(negedge clock);
    fif.redirect_valid = rv; fif.pc_index_valid = piv; fif.pc_index = pc;
    ddr_ready = rdy; ddr_operation_done = dn; ddr_opload_rdata = rd;
    #1;
    check_eq("pc_index_ready", 64'(fif.pc_index_ready), 64'(!m_req && !m_fly && !rv));
    check_eq("ddr_chip_enable", 64'(ddr_chip_enable), 64'(m_req));
    check_eq("ddr_write_enable", 64'(ddr_write_enable), 64'(0));
    check_eq("ddr_index", 64'(ddr_index), 64'(m_idx));
    check_eq("pc_operation_done", 64'(fif.pc_operation_done), 64'(m_pulse && !rv));
    check_eq("pc_read_inst", fif.pc_read_inst, m_inst);
    check_eq("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(m_fetch));
    check_eq("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_flush));
    @(posedge clock);
    m_pulse = 0;
    if (m_req) begin
      if (rdy) begin
        m_req = 0; m_fly = 1; m_killed = rv;
        if (rv) m_flush++;
      end else if (rv) begin
        m_req = 0; m_flush++;
      end
    end else if (m_fly) begin
      if (dn) begin
        m_fly = 0;
        if (!m_killed && !rv) begin
          m_inst = rd; m_pulse = 1; m_fetch++;
        end else if (!m_killed) begin
          m_flush++;
        end
      end else if (rv && !m_killed) begin
        m_killed = 1; m_flush++;
      end
    end else if (piv && !rv) begin
      m_req = 1; m_idx = pc[21:3];
    end
  endtask

  initial begin
    int cd;
    logic prev_req, rv, piv, rdy, dn;
    logic [63:0] pc, rd;

    model_clear();
    do_reset();
    check_eq("reset_ce", 64'(ddr_chip_enable), 64'(0));
    check_eq("reset_idx", 64'(ddr_index), 64'(0));
    check_eq("reset_inst", fif.pc_read_inst, 64'(0));

    // Basic fetch
    step(0, 1, 64'h8000_0010, 0, 0, 0);
    #2;
    check_eq("basic_ce", 64'(ddr_chip_enable), 64'(1));
    check_eq("basic_idx", 64'(ddr_index), 64'h2);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 64'h0000_0013_0000_0093);
    #2;
    check_eq("basic_done", 64'(fif.pc_operation_done), 64'(1));
    check_eq("basic_inst", fif.pc_read_inst, 64'h0000_0013_0000_0093);
    check_eq("basic_fcnt", 64'(perf_fetch_cnt), 64'(1));
    step(0, 0, 0, 0, 0, 0);

    // Redirect in REQ
    step(0, 1, 64'h40, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    #2;
    check_eq("req_redir_ce", 64'(ddr_chip_enable), 64'(0));
    check_eq("req_redir_flush", 64'(perf_flush_cnt), 64'(1));
    step(0, 0, 0, 0, 0, 0);

    // Redirect in WAIT, two cycles before done; then a normal fetch
    step(0, 1, 64'h1238, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 64'h5550, 0, 0, 0);
    step(0, 0, 0, 0, 1, 64'hBAD0_BAD0_BAD0_BAD0);
    step(0, 1, 64'h88, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 64'h1111);
    step(0, 0, 0, 0, 0, 0);

    // Redirect coincident with done
    step(0, 1, 64'h90, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 64'hDEAD);
    #2;
    check_eq("coinc_inst", fif.pc_read_inst, 64'h1111);
    check_eq("coinc_flush", 64'(perf_flush_cnt), 64'(3));
    step(0, 0, 0, 0, 0, 0);

    // Back-to-back: each new request issued in the done-pulse cycle
    do_reset();
    step(0, 1, 64'h100, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 64'hA0 + 64'(i));
      step(0, i < 3, 64'h108 + 64'(8 * i), 0, 0, 0);
    end
    check_eq("b2b_fcnt", 64'(perf_fetch_cnt), 64'(4));

    // Reset mid-WAIT, then a stray completion
    step(0, 1, 64'h200, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    do_reset();
    check_eq("rst_ready", 64'(fif.pc_index_ready), 64'(1));
    check_eq("rst_fcnt", 64'(perf_fetch_cnt), 64'(0));
    step(0, 0, 0, 0, 1, 64'h7777);
    step(0, 0, 0, 0, 0, 0);
    check_eq("stray_inst", fif.pc_read_inst, 64'(0));

    // Randomized traffic with a DDR responder of 1..3 cycle read latency
    cd = 0;
    for (int c = 0; c < 1500; c++) begin
      rv  = ($urandom_range(0, 7) == 0);
      piv = $urandom_range(0, 1) != 0;
      pc  = {$urandom, $urandom};
      rdy = $urandom_range(0, 2) != 0;
      dn  = (cd == 1);
      rd  = {$urandom, $urandom};
      prev_req = m_req;
      step(rv, piv, pc, rdy, dn, rd);
      if (dn) cd = 0;
      else if (cd > 1) cd--;
      if (prev_req && rdy) cd = $urandom_range(1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_resp_ctrl.md
# fetch_resp_ctrl

Responder side of the instruction-fetch request channel. Accepts `pc_index` requests from the fetch PC controller and issues a single 64-bit DDR read. It returns the fetched doubleword to the frontend with a one-cycle `pc_operation_done` pulse. Responses belonging to a request overtaken by a redirect are suppressed, so the PC controller never advances on stale data. Sits in the channel arbiter between the frontend PC controller and the DDR port.

## Interface
- `ADDR_W`, 64: request address width.
- `DATA_W`, 64: DDR read data width.
- `IDX_LSB`, 3: lowest PC bit used for the DDR index.
- `IDX_W`, 19: DDR index width; index = `pc_index[IDX_LSB+IDX_W-1:IDX_LSB]` = bits [21:3].
- `CNT_W`, 32: perf counter width.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `redirect_valid` in 1: frontend flush; kills the current fetch.
- `pc_index_valid` in 1: fetch request valid.
- `pc_index` in ADDR_W: fetch address.
- `pc_index_ready` out 1: request accepted this cycle if valid; combinational.
- `pc_operation_done` out 1: one-cycle pulse, fetched data valid.
- `pc_read_inst` out DATA_W: fetched doubleword; holds its value until the next done.
- `ddr_chip_enable` out 1: DDR read request.
- `ddr_write_enable` out 1: tied 0.
- `ddr_index` out IDX_W: DDR doubleword index.
- `ddr_ready` in 1: DDR accepts the request this cycle.
- `ddr_operation_done` in 1: DDR read complete.
- `ddr_opload_rdata` in DATA_W: read data, valid with `ddr_operation_done`.
- `perf_fetch_cnt` out CNT_W: delivered fetches.
- `perf_flush_cnt` out CNT_W: discarded fetches.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - `pc_index_ready` = 1 & ~`redirect_valid`.
  - On handshake, latch the index from `pc_index[21:3]` into `ddr_index` and go to REQ. Address bits [2:0] and bits above 21 are ignored.
- REQ:
  - `ddr_chip_enable` = 1 with `ddr_index` stable.
  - `ddr_ready` → WAIT.
  - `redirect_valid` & ~`ddr_ready` → IDLE. No DDR traffic occurs; `perf_flush_cnt` +1.
  - `redirect_valid` & `ddr_ready` → DRAIN.
- WAIT:
  - `ddr_operation_done` & ~`redirect_valid` → register `ddr_opload_rdata` into `pc_read_inst`, pulse `pc_operation_done` next cycle, `perf_fetch_cnt` +1, go to IDLE.
  - `redirect_valid` (with or without done) → discard. Done in the same cycle → IDLE, otherwise → DRAIN. `perf_flush_cnt` +1.
- DRAIN:
  - `pc_index_ready` = 0; wait for `ddr_operation_done`, discard the data, go to IDLE.
  - Further redirects are ignored.
- `ddr_operation_done` in IDLE or REQ is ignored; it is a stray completion after reset.
- At most one DDR read is outstanding.
- Counters wrap modulo 2^CNT_W.
- `pc_operation_done` is never asserted in a cycle where `redirect_valid` is high.

## Timing
- Reset values:
  - state IDLE.
  - `pc_operation_done` = 0, `ddr_chip_enable` = 0, `ddr_write_enable` = 0.
  - `ddr_index` = 0, `pc_read_inst` = 0.
  - Both counters 0.
- Reset mid-operation returns to IDLE at once. The pending DDR completion is then ignored in IDLE.
- Handshake in cycle N → `ddr_chip_enable` high from N+1.
- `ddr_ready` in cycle M → WAIT from M+1.
- `ddr_operation_done` in cycle K (in WAIT) → `pc_operation_done` and new `pc_read_inst` in K+1.
- Minimum request-to-done latency is 3 cycles, with `ddr_ready` at N+1 and DDR done at N+2.
- In the done-pulse cycle the state is IDLE, so a new request can be accepted that same cycle.

## Structure
- Shared frontend package holds:
  - The state enum (IDLE/REQ/WAIT/DRAIN).
  - Constants `FETCH_IDX_LSB` = 3 and `FETCH_IDX_W` = 19.
  - The DDR data width.
- One natural sub-module: `perf_cnt`, a CNT_W wrapping counter with increment enable and synchronous reset, instantiated twice.

## Test plan
- **Basic fetch:** `pc_index` = 0x8000_0010 accepted. Expect:
  - `ddr_index` = 0x2 with `ddr_chip_enable` high next cycle.
  - With `ddr_ready` one cycle later and done with rdata 0x0000_0013_0000_0093 one cycle after that, `pc_operation_done` pulses once with `pc_read_inst` = 0x0000_0013_0000_0093.
  - `perf_fetch_cnt` = 1.
- **Redirect in REQ:** hold `ddr_ready` = 0 and assert `redirect_valid` one cycle. Expect:
  - IDLE next cycle with `ddr_chip_enable` = 0.
  - No done pulse; `perf_flush_cnt` = 1.
- **Redirect in WAIT:**
  - Redirect two cycles before `ddr_operation_done` → DRAIN, `pc_index_ready` = 0 until done, no pulse, data discarded.
  - A request issued afterwards completes normally.
- **Redirect coincident with done:** no pulse, `pc_read_inst` unchanged, IDLE next cycle, `perf_flush_cnt` +1.
- **Back-to-back:** new valid in the done-pulse cycle is accepted; 4 sequential fetches → `perf_fetch_cnt` = 4.
- **Reset mid-WAIT, then stray done:** stray `ddr_operation_done` after reset is ignored. All outputs at reset values and state IDLE.
